muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit that answers operation requests issued by the core datapath.
- The datapath drives operands and an M-extension funct3 code and pulses `start`. This block computes over multiple cycles and reports completion with `ready`.
- This is the responder end of the datapath's multi-cycle execute handshake. `flush` is the datapath's PC-change abort.

Parameters:
- WIDTH, 32, operand/result width in bits; the counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset: state resets on a posedge clk where rst==0.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- dataA  input  WIDTH  rs1 operand; captured when start is accepted.
- dataB  input  WIDTH  rs2 operand; captured when start is accepted.
- flush  input  1  abort the current operation; return to IDLE.
- busy  output  1  high while in MUL or DIV state.
- ready  output  1  result valid; high in DONE only.
- result  output  WIDTH  result of the last completed operation.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; busy=0, ready=0, result=0; counter and internal registers cleared.
  - Reset takes priority over flush and start, including mid-operation.
- States: IDLE, MUL, DIV, DONE.
- Accept: start==1 in IDLE or DONE (and flush==0) at a posedge.
  - Latch op, dataA, dataB.
  - Go to MUL (op[2]==0) or DIV (op[2]==1); ready drops in the same edge.
  - start while busy is ignored; operands are not re-latched.
- Signedness:
  - Signed operands use magnitudes; the sign is applied at completion.
  - MULH: A and B signed. MULHSU: A signed, B unsigned. DIV/REM: both signed. Others: unsigned.
- MUL:
  - Radix-2 shift-add on a 2*WIDTH product, one bit per cycle, exactly WIDTH iteration cycles.
  - Then DONE, with result = low word (MUL) or high word (MULH*) of the sign-corrected product.
  - Latency: ready is high WIDTH+1 edges after the accepting edge (33 for WIDTH=32).
- DIV:
  - Restoring division, one quotient bit per cycle, WIDTH cycles, same latency as MUL.
  - Quotient is negated if the signs differ (signed ops).
  - Remainder takes the dividend's sign.
- Special cases, detected at accept; the unit goes to DONE on the next edge (latency 1):
  - Divide by zero: DIV/DIVU result=all ones; REM/REMU result=dataA.
  - Signed overflow (dataA=0x80000000, dataB=0xFFFFFFFF): DIV result=0x80000000; REM result=0.
- DONE:
  - ready=1 and result is held stable until start is accepted or flush is seen.
  - A new start in DONE is accepted directly; there is no IDLE bubble.
- flush==1 at a posedge (rst==1):
  - Next state=IDLE, busy=0, ready=0; result keeps its last value.
  - flush has priority over a simultaneous start, which is dropped.
- Counter:
  - Loads WIDTH on accept and decrements each iteration cycle.
  - The transition to DONE occurs on the edge where the counter reaches 1 (no wrap-around).
- Outputs are registered; there is no combinational path from inputs to ready or result.

Test Plan:
- Reset mid-DIV: rst=0 at cycle 10 of a DIVU -> next cycle busy=0, ready=0, result=0; a subsequent start behaves normally.
- MUL and MULHU: MUL 7*6 -> result 42 after 33 cycles with busy high for 32 cycles. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- Signed forms:
  - MULH 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
  - DIV -7/2 -> 0xFFFFFFFD.
  - REM -7/2 -> 0xFFFFFFFF.
- Special cases:
  - DIVU 100/0 -> 0xFFFFFFFF; REM 100/0 -> 100; each with ready one cycle after accept.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM for the same operands -> 0.
- Handshake:
  - start pulsed again at cycle 5 of a MUL with new operands -> ignored; the original result is returned at cycle 33.
  - Back-to-back start in DONE -> ready drops next edge and the new op completes 33 cycles later.
- Flush:
  - flush at cycle 20 of a DIV with start also high -> IDLE next cycle, ready never asserts, result unchanged.
  - A later DIVU 100/7 -> 14.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/response bundle between the core datapath and the iterative
// multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             flush;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, dataA, dataB, flush,
        input  busy, ready, result
    );

    modport slave (
        input  start, op, dataA, dataB, flush,
        output busy, ready, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, signs applied on the final cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    muldiv_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   b_mag_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [CW-1:0]      cnt_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   result_r;
    logic               busy_r;
    logic               ready_r;
    logic               busy_nx_s;
    logic               ready_nx_s;

    logic               a_signed_s;
    logic               b_signed_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic               div_zero_s;
    logic               div_ovf_s;
    logic               special_s;
    logic [WIDTH-1:0]   special_res_s;
    logic               last_iter_s;

    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] prod_nx_s;
    logic [2*WIDTH-1:0] prod_fin_s;
    logic [WIDTH-1:0]   mul_res_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_sub_s;
    logic [WIDTH-1:0]   rem_nx_s;
    logic [WIDTH-1:0]   quo_nx_s;
    logic [WIDTH-1:0]   quo_fin_s;
    logic [WIDTH-1:0]   rem_fin_s;
    logic [WIDTH-1:0]   div_res_s;

    assign bus.busy   = busy_r;
    assign bus.ready  = ready_r;
    assign bus.result = result_r;

    // Operand sign decode, magnitudes and accept-time special cases.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (bus.op)
            3'b001:         begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'b010:         begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            3'b100, 3'b110: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default:        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
        a_neg_s    = a_signed_s & bus.dataA[WIDTH-1];
        b_neg_s    = b_signed_s & bus.dataB[WIDTH-1];
        a_mag_s    = a_neg_s ? (ZERO_W - bus.dataA) : bus.dataA;
        b_mag_s    = b_neg_s ? (ZERO_W - bus.dataB) : bus.dataB;
        div_zero_s = bus.op[2] & (bus.dataB == ZERO_W);
        div_ovf_s  = bus.op[2] & ~bus.op[0] & (bus.dataA == MIN_W) & (bus.dataB == ONES_W);
        special_s  = div_zero_s | div_ovf_s;
        if (div_zero_s) begin
            special_res_s = bus.op[1] ? bus.dataA : ONES_W;
        end else if (div_ovf_s) begin
            special_res_s = bus.op[1] ? ZERO_W : MIN_W;
        end else begin
            special_res_s = ZERO_W;
        end
    end

    // One shift-add / restoring-subtract step plus final sign correction.
    always_comb begin
        last_iter_s = (cnt_r == CNT_ONE);
        mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                      (prod_r[0] ? {1'b0, b_mag_r} : {(WIDTH+1){1'b0}});
        prod_nx_s   = {mul_sum_s, prod_r[WIDTH-1:1]};
        prod_fin_s  = neg_q_r ? ({(2*WIDTH){1'b0}} - prod_nx_s) : prod_nx_s;
        mul_res_s   = (op_r[1:0] == 2'b00) ? prod_fin_s[WIDTH-1:0]
                                           : prod_fin_s[2*WIDTH-1:WIDTH];
        div_shift_s = {rem_r, quo_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_mag_r});
        // When the subtract is taken the true difference is below b, so the low word is exact.
        div_sub_s   = div_shift_s[WIDTH-1:0] - b_mag_r;
        rem_nx_s    = div_ge_s ? div_sub_s : div_shift_s[WIDTH-1:0];
        quo_nx_s    = {quo_r[WIDTH-2:0], div_ge_s};
        quo_fin_s   = neg_q_r ? (ZERO_W - quo_nx_s) : quo_nx_s;
        rem_fin_s   = neg_r_r ? (ZERO_W - rem_nx_s) : rem_nx_s;
        div_res_s   = op_r[1] ? rem_fin_s : quo_fin_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; flush outranks start.
    always_comb begin
        state_nx_s = state_r;
        if (bus.flush) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        if (special_s) begin
                            state_nx_s = ST_DONE;
                        end else begin
                            state_nx_s = bus.op[2] ? ST_DIV : ST_MUL;
                        end
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (last_iter_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode from the upcoming state, so the flags are registered.
    always_comb begin
        busy_nx_s  = 1'b0;
        ready_nx_s = 1'b0;
        case (state_nx_s)
            ST_MUL, ST_DIV: begin busy_nx_s = 1'b1; ready_nx_s = 1'b0; end
            ST_DONE:        begin busy_nx_s = 1'b0; ready_nx_s = 1'b1; end
            default:        begin busy_nx_s = 1'b0; ready_nx_s = 1'b0; end
        endcase
    end

    // Registered handshake flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            busy_r  <= busy_nx_s;
            ready_r <= ready_nx_s;
        end
    end

    // Datapath: operand capture, iteration, result write-back.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_r     <= 3'b000;
            b_mag_r  <= ZERO_W;
            prod_r   <= {(2*WIDTH){1'b0}};
            rem_r    <= ZERO_W;
            quo_r    <= ZERO_W;
            cnt_r    <= {CW{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= ZERO_W;
        end else if (!bus.flush) begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        op_r    <= bus.op;
                        b_mag_r <= b_mag_s;
                        prod_r  <= {ZERO_W, a_mag_s};
                        rem_r   <= ZERO_W;
                        quo_r   <= a_mag_s;
                        cnt_r   <= CNT_MAX;
                        neg_q_r <= a_neg_s ^ b_neg_s;
                        neg_r_r <= a_neg_s;
                        if (special_s) begin
                            result_r <= special_res_s;
                        end
                    end
                end
                ST_MUL: begin
                    prod_r <= prod_nx_s;
                    cnt_r  <= cnt_r - CNT_ONE;
                    if (last_iter_s) begin
                        result_r <= mul_res_s;
                    end
                end
                ST_DIV: begin
                    rem_r <= rem_nx_s;
                    quo_r <= quo_nx_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (last_iter_s) begin
                        result_r <= div_res_s;
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at request
// time and compared when ready rises.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    endtask

    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint       sa, sb, p;
        logic [63:0]  up;
        logic [W-1:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: begin up = {32'd0, a} * {32'd0, b}; r = up[31:0]; end
            3'b001: begin p = sa * sb; up = p; r = up[63:32]; end
            3'b010: begin p = sa * longint'({32'd0, b}); up = p; r = up[63:32]; end
            3'b011: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
            3'b100: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = W'(sa / sb);
            end
            3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = W'(sa % sb);
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one request at the current negedge, wait for ready, score it.
    // ign_at > 0 pulses a second (to-be-ignored) start at that cycle.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] expv, input int lat_exp, input string tag,
                          input int ign_at);
        int n;
        int busy_n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.dataA = a;
        bus.dataB = b;
        exp_q.push_back(expv);
        @(negedge clk);
        bus.start = 1'b0;
        bus.dataA = $urandom;
        bus.dataB = $urandom;
        n = 1;
        busy_n = 0;
        if (lat_exp > 1) check_val({tag, "_rdy_drop"}, W'(bus.ready), 32'd0);
        while (!bus.ready && n < 200) begin
            if (bus.busy) busy_n++;
            if (ign_at != 0 && n == ign_at) begin
                bus.start = 1'b1;
                bus.op    = 3'b011;
                bus.dataA = 32'hDEAD_BEEF;
                bus.dataB = 32'h1234_5678;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check_val({tag, "_lat"}, W'(n), W'(lat_exp));
        check_val({tag, "_busy_cycles"}, W'(busy_n), W'(lat_exp - 1));
        last_res = exp_q.pop_front();
        check_val({tag, "_res"}, bus.result, last_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_seen;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 3'b000;
        bus.dataA = 32'd0;
        bus.dataB = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst_busy",   W'(bus.busy),  32'd0);
        check_val("rst_ready",  W'(bus.ready), 32'd0);
        check_val("rst_result", bus.result,    32'd0);
        rst = 1'b1;

        run_op(3'b000, 32'd7, 32'd6, 32'd42, 33, "mul_7x6", 0);

        // Reset in the middle of a DIVU.
        bus.start = 1'b1; bus.op = 3'b101; bus.dataA = 32'd1000; bus.dataB = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_busy",   W'(bus.busy),  32'd0);
        check_val("midrst_ready",  W'(bus.ready), 32'd0);
        check_val("midrst_result", bus.result,    32'd0);
        rst = 1'b1;

        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max", 0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, "mulh_m1x2", 0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1", 0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_m7_2", 0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem_m7_2", 0);
        run_op(3'b101, 32'd100,       32'd0,         32'hFFFF_FFFF, 1,  "divu_by0", 0);
        run_op(3'b110, 32'd100,       32'd0,         32'd100,       1,  "rem_by0", 0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf", 0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf", 0);
        run_op(3'b000, 32'd12345,     32'd678,       32'd8369910,   33, "mul_ignore", 5);

        // Back-to-back: new start while DONE is still showing ready.
        check_val("b2b_pre_ready", W'(bus.ready), 32'd1);
        run_op(3'b111, 32'd1000, 32'd7, 32'd6, 33, "b2b_remu", 0);

        // Flush at cycle 20 of a DIV with a competing start.
        bus.start = 1'b1; bus.op = 3'b100; bus.dataA = 32'd5000; bus.dataB = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        bus.flush = 1'b1; bus.start = 1'b1; bus.op = 3'b101;
        bus.dataA = 32'd77; bus.dataB = 32'd5;
        @(negedge clk);
        bus.flush = 1'b0; bus.start = 1'b0;
        check_val("flush_busy",   W'(bus.busy),  32'd0);
        check_val("flush_ready",  W'(bus.ready), 32'd0);
        check_val("flush_result", bus.result,    last_res);
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready || bus.busy) rdy_seen++;
        end
        check_val("flush_quiet", W'(rdy_seen), 32'd0);
        check_val("flush_hold",  bus.result, last_res);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu_100_7", 0);

        for (int k = 0; k < 8; k++) begin
            logic [2:0]   rop;
            logic [W-1:0] ra, rb;
            int           rl;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (k == 3) ? 32'd0 : $urandom;
            rl  = (rop[2] && (rb == 32'd0 ||
                   (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) ? 1 : 33;
            run_op(rop, ra, rb, ref_model(rop, ra, rb), rl, "rand", 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
